// File: rtl/iter_shifter_mips_if.sv
// iter_shifter_mips_if: start/busy/done request bus between the ALU control FSM (master) and the iterative shifter (slave)
//  start, op, shamt, in0 : request from master; busy, done, out : status and result from slave
interface iter_shifter_mips_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [1:0]         op;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   in0;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   out;
  modport master (output start, op, shamt, in0, input busy, done, out);
  modport slave  (input start, op, shamt, in0, output busy, done, out);
endinterface

// File: rtl/iter_shifter_mips.sv
// iter_shifter_mips: multi-cycle SLL/SRL/SRA(/ROTR) unit moving 2 bit positions per cycle plus a final 1-bit step for odd counts
//  clk, rst : clock, synchronous active-high reset
//  sh_if    : slave side of iter_shifter_mips_if (start/op/shamt/in0 in, busy/done/out out)
//  ITER_SHIFTER_ROTATE_EN : when defined op=11 rotates right, otherwise op=11 is SRL
module iter_shifter_mips #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  iter_shifter_mips_if.slave  sh_if
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d, out_q, out_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               two;
  logic [WIDTH-1:0]   sll_r, srl_r, sra_r, shr_r, step_r;
  assign two   = cnt_q >= SHAMT_W'(2);
  assign sll_r = two ? {data_q[WIDTH-3:0], 2'b00} : {data_q[WIDTH-2:0], 1'b0};
  assign srl_r = two ? {2'b00, data_q[WIDTH-1:2]} : {1'b0, data_q[WIDTH-1:1]};
  // the MSB of data_q never changes under SRA, so it still carries the latched sign
  assign sra_r = two ? {{2{data_q[WIDTH-1]}}, data_q[WIDTH-1:2]} : {data_q[WIDTH-1], data_q[WIDTH-1:1]};
`ifdef ITER_SHIFTER_ROTATE_EN
  logic [WIDTH-1:0] rot_r;
  assign rot_r = two ? {data_q[1:0], data_q[WIDTH-1:2]} : {data_q[0], data_q[WIDTH-1:1]};
  assign shr_r = op_q == 2'b11 ? rot_r : srl_r;
`else
  assign shr_r = srl_r;
`endif
  assign step_r = op_q == 2'b00 ? sll_r : op_q == 2'b10 ? sra_r : shr_r;
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    if (state_q == SHIFT) begin
      data_d = step_r;
      cnt_d  = cnt_q - (two ? SHAMT_W'(2) : SHAMT_W'(1));
      if (cnt_d == '0) begin
        state_d = DONE;
        out_d   = step_r;
      end
    end else if (sh_if.start) begin
      data_d  = sh_if.in0;
      op_d    = sh_if.op;
      cnt_d   = sh_if.shamt;
      state_d = sh_if.shamt == '0 ? DONE : SHIFT;
      out_d   = sh_if.shamt == '0 ? sh_if.in0 : out_q;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end
  assign sh_if.busy = state_q == SHIFT;
  assign sh_if.done = state_q == DONE;
  assign sh_if.out  = out_q;
endmodule
